// File: rtl/hms_offset_counter.sv
// hms_offset_counter: HH:MM:SS time-of-day counter held as six BCD digits.
// Each digit is emitted as code = (digit + CODE_OFFSET) mod 16 for the downstream decoder.
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous reset, active-high
//   i_tick       one-cycle 1 Hz advance pulse (ignored while i_set_en=1)
//   i_set_en     setting mode; counting paused
//   i_set_sel    field select: 00 seconds, 01 minutes, 10 hours, 11 none
//   i_set_inc    one-cycle adjust pulse for the selected field (only while i_set_en=1)
//   o_s_lo/hi, o_m_lo/hi, o_h_lo/hi   coded digits
//   o_upd        one-cycle strobe, digits changed this cycle
//   o_day_roll   one-cycle pulse on the 23:59:59 -> 00:00:00 wrap (24h mode only)
module hms_offset_counter #(
  parameter int unsigned CODE_OFFSET = 10,
  parameter bit          TWELVE_HR   = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_set_en,
  input  logic [1:0] i_set_sel,
  input  logic       i_set_inc,
  output logic [3:0] o_s_lo,
  output logic [3:0] o_s_hi,
  output logic [3:0] o_m_lo,
  output logic [3:0] o_m_hi,
  output logic [3:0] o_h_lo,
  output logic [3:0] o_h_hi,
  output logic       o_upd,
  output logic       o_day_roll
);

  localparam logic [3:0] Off    = 4'(CODE_OFFSET);
  localparam logic [3:0] RstHHi = TWELVE_HR ? 4'd1 : 4'd0;
  localparam logic [3:0] RstHLo = TWELVE_HR ? 4'd2 : 4'd0;
  localparam logic [3:0] WrapHLo = TWELVE_HR ? 4'd1 : 4'd0;

  logic [3:0] r_s_lo, r_s_hi, r_m_lo, r_m_hi, r_h_lo, r_h_hi;
  logic       r_upd, r_day_roll;

  logic [3:0] w_s_lo_d, w_s_hi_d, w_m_lo_d, w_m_hi_d, w_h_lo_d, w_h_hi_d;
  logic       w_upd_d, w_day_roll_d;

  logic       w_run, w_set;
  logic       w_s_carry, w_m_carry, w_h_wrap;
  logic [3:0] w_m_inc_lo, w_m_inc_hi, w_h_inc_lo, w_h_inc_hi;

  assign w_run = i_tick & ~i_set_en;
  assign w_set = i_set_inc & i_set_en;

  assign w_s_carry = (r_s_lo == 4'd9) && (r_s_hi == 4'd5);
  assign w_m_carry = (r_m_lo == 4'd9) && (r_m_hi == 4'd5);
  // Last hour of the cycle: 23 in 24h mode, 12 in 12h mode.
  assign w_h_wrap  = TWELVE_HR ? ((r_h_hi == 4'd1) && (r_h_lo == 4'd2))
                               : ((r_h_hi == 4'd2) && (r_h_lo == 4'd3));

  // Minutes +1 mod 60, shared by the run carry and set mode.
  always_comb begin
    w_m_inc_lo = r_m_lo + 4'd1;
    w_m_inc_hi = r_m_hi;
    if (r_m_lo == 4'd9) begin
      w_m_inc_lo = 4'd0;
      w_m_inc_hi = (r_m_hi == 4'd5) ? 4'd0 : r_m_hi + 4'd1;
    end
  end

  // Hours +1 with the mode wrap; 09 -> 10 falls out of the low-digit carry.
  always_comb begin
    w_h_inc_lo = r_h_lo + 4'd1;
    w_h_inc_hi = r_h_hi;
    if (w_h_wrap) begin
      w_h_inc_lo = WrapHLo;
      w_h_inc_hi = 4'd0;
    end else if (r_h_lo == 4'd9) begin
      w_h_inc_lo = 4'd0;
      w_h_inc_hi = r_h_hi + 4'd1;
    end
  end

  always_comb begin
    w_s_lo_d     = r_s_lo;
    w_s_hi_d     = r_s_hi;
    w_m_lo_d     = r_m_lo;
    w_m_hi_d     = r_m_hi;
    w_h_lo_d     = r_h_lo;
    w_h_hi_d     = r_h_hi;
    w_upd_d      = 1'b0;
    w_day_roll_d = 1'b0;
    if (w_run) begin
      w_upd_d  = 1'b1;
      w_s_lo_d = (r_s_lo == 4'd9) ? 4'd0 : r_s_lo + 4'd1;
      if (r_s_lo == 4'd9) begin
        w_s_hi_d = (r_s_hi == 4'd5) ? 4'd0 : r_s_hi + 4'd1;
      end
      if (w_s_carry) begin
        w_m_lo_d = w_m_inc_lo;
        w_m_hi_d = w_m_inc_hi;
        if (w_m_carry) begin
          w_h_lo_d     = w_h_inc_lo;
          w_h_hi_d     = w_h_inc_hi;
          w_day_roll_d = ~TWELVE_HR & w_h_wrap;
        end
      end
    end else if (w_set) begin
      case (i_set_sel)
        2'b00: begin
          w_s_lo_d = 4'd0;
          w_s_hi_d = 4'd0;
          w_upd_d  = 1'b1;
        end
        2'b01: begin
          w_m_lo_d = w_m_inc_lo;
          w_m_hi_d = w_m_inc_hi;
          w_upd_d  = 1'b1;
        end
        2'b10: begin
          w_h_lo_d = w_h_inc_lo;
          w_h_hi_d = w_h_inc_hi;
          w_upd_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s_lo     <= 4'd0;
      r_s_hi     <= 4'd0;
      r_m_lo     <= 4'd0;
      r_m_hi     <= 4'd0;
      r_h_lo     <= RstHLo;
      r_h_hi     <= RstHHi;
      r_upd      <= 1'b0;
      r_day_roll <= 1'b0;
    end else begin
      r_s_lo     <= w_s_lo_d;
      r_s_hi     <= w_s_hi_d;
      r_m_lo     <= w_m_lo_d;
      r_m_hi     <= w_m_hi_d;
      r_h_lo     <= w_h_lo_d;
      r_h_hi     <= w_h_hi_d;
      r_upd      <= w_upd_d;
      r_day_roll <= w_day_roll_d;
    end
  end

  assign o_s_lo     = r_s_lo + Off;
  assign o_s_hi     = r_s_hi + Off;
  assign o_m_lo     = r_m_lo + Off;
  assign o_m_hi     = r_m_hi + Off;
  assign o_h_lo     = r_h_lo + Off;
  assign o_h_hi     = r_h_hi + Off;
  assign o_upd      = r_upd;
  assign o_day_roll = r_day_roll;

endmodule

// File: doc/hms_offset_counter.md
Name: hms_offset_counter

Overview:
Time-of-day counter for the digital clock, kept internally as BCD digits (HH:MM:SS).
It emits each digit in the offset-10 display code, code = (digit + CODE_OFFSET) mod 16, which is the code the digit decoder downstream converts back to plain BCD.
It sits between the 1 Hz tick generator and the per-digit decoders/7-seg drivers.
It also supports manual time setting from push-button pulses.

Parameters:
CODE_OFFSET, 10, added mod 16 to every BCD digit on output; must stay 10 to match the decoder.
TWELVE_HR, 0, 0 = 24-hour (hours 00..23); 1 = 12-hour (hours 01..12).

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous reset, active-high.
tick  in  1  one-cycle 1 Hz advance pulse.
set_en  in  1  1 = setting mode; the clock is paused.
set_sel  in  2  field to set: 00 seconds, 01 minutes, 10 hours, 11 none.
set_inc  in  1  one-cycle pulse; adjusts the selected field while set_en=1.
s_lo, s_hi  out  4 each  seconds digits, coded.
m_lo, m_hi  out  4 each  minutes digits, coded.
h_lo, h_hi  out  4 each  hours digits, coded.
upd  out  1  one-cycle strobe: digit outputs changed this cycle.
day_roll  out  1  one-cycle pulse on the end-of-day wrap.

Behaviour:
- Reset (rst=1 at a clk edge, overriding all other inputs):
  - 24h mode: time = 00:00:00, so all six digit outputs = 4'b1010.
  - 12h mode: time = 12:00:00, so h_hi = 4'b1011, h_lo = 4'b1100, all others 4'b1010.
  - upd = 0, day_roll = 0.
- Reset mid-count or mid-set: same result; no pending pulse survives.
- State: six 4-bit BCD registers.
  - Each digit output is a combinational encode of its own register: 0→1010, 1→1011, ... 5→1111, 6→0000, ... 9→0011.
  - Output codes are only produced for digits 0..9. A BCD register must never hold 10..15.
- Run mode (set_en=0), on tick=1: advance one second with ripple carry.
  - s_lo 9→0 carries into s_hi.
  - s_hi 5→0 carries into m_lo.
  - m_lo 9→0 carries into m_hi.
  - m_hi 5→0 carries into the hours.
- Hours in 24h mode: 23→00. This wrap asserts day_roll in the cycle after the tick edge, together with upd.
- Hours in 12h mode: 12→01 and 09→10; day_roll is never asserted.
- Latency:
  - Registers update on the tick edge; the new codes are visible the following cycle.
  - upd is registered and high exactly that following cycle, once per tick.
- Set mode (set_en=1):
  - tick is ignored and dropped, not queued.
  - set_inc with set_sel=00: seconds cleared to 00.
  - set_inc with set_sel=01: minutes +1, 59→00, no carry into hours.
  - set_inc with set_sel=10: hours +1 with the mode wrap (23→00 or 12→01); no day_roll.
  - set_inc with set_sel=11: no change, upd stays 0.
  - upd pulses one cycle after each effective set_inc.
- set_inc is ignored when set_en=0.
- tick and set_inc in the same cycle: the result is decided by set_en (only one of them can act).
- Back-to-back ticks in consecutive cycles must each advance the time (no lost counts).
- No state machine beyond the run/set qualification. Each digit is a mod-N counter enabled by the carry chain.

Test Plan:
- Reset, 24h → all digits 1010, upd=0; 12h → h_hi=1011, h_lo=1100.
- 24h: 59 ticks from reset → s_hi=1111, s_lo=0011. One more tick → seconds 1010/1010, m_lo=1011, upd high one cycle.
- Set hours to 23 via 23 set_inc (set_sel=10), minutes to 59, then set_en=0. 59 ticks, then one more → all digits 1010, day_roll=1 for exactly one cycle.
- set_en=1 with tick pulsed 5 times → time unchanged, upd=0. Then set_sel=10 set_inc at 23 → hours 00 (1010/1010), minutes unchanged, day_roll=0.
- 12h: set to 12:59:59, one tick → h_hi=1010, h_lo=1011, m and s digits 1010. From 09:59:59, one tick → h_hi=1011, h_lo=1010.
- rst asserted for one cycle at 00:05:30 in the same cycle as tick → next cycle all 1010 (24h), upd=0, day_roll=0.
